retospect_tickgen: RTL and testbench
====================================

RETOSPECT_TICKGEN -- requirements
Module: retospect_tickgen

Interface
REQ-001 Parameter N_CH, default 6: number of programmable tick channels (1..16).
REQ-002 Parameter CNT_W, default 8: width of each channel's period and counter registers (2..16).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-005 config_en  input  1  high = shift the configuration chain; counters frozen.
REQ-006 bs_in  input  1  configuration serial data in.
REQ-007 bs_out  output  1  configuration serial data out, for daisy-chaining to the next block.
REQ-008 restart  input  1  synchronous network restart; clears counters and outputs, keeps configuration.
REQ-009 tick_bus  output  N_CH+2  bit0 constant 0, bit1 constant 1, bit k+2 = channel k output.

Function
REQ-010 Each channel SHALL have a CNT_W+2-bit shift field {en, mode, max[CNT_W-1:0]}, with en as MSB; total chain length is N_CH*(CNT_W+2).
REQ-011 While config_en=1, each cycle: bs_in enters the MSB of channel 0's field; every field shifts right by one; each field's LSB feeds the MSB of the next channel; bs_out = LSB of channel N_CH-1's field (combinational from the register).
REQ-012 Shift fields SHALL be separate from active registers; counting SHALL use active en/mode/max only.
REQ-013 Commit: the first cycle with config_en=0 after a cycle with config_en=1 SHALL copy all shift fields into the active registers, clear all counters to 0, and clear all channel outputs to 0.
REQ-014 Priority per edge: reset > restart > config_en shift > commit > count.
REQ-015 restart=1 SHALL clear counters and outputs, leave active and shift registers unchanged, and suppress a pending commit (the commit occurs on the next edge with restart=0 and config_en=0).
REQ-016 While config_en=1, counters and channel outputs SHALL hold their values.
REQ-017 Count, en=1: if count==max then count<=0 and "fire", else count<=count+1; period = max+1 cycles.
REQ-018 max=0 SHALL fire every cycle; max=2^CNT_W-1 SHALL wrap to 0 via the match, with no overflow path.
REQ-019 mode=0 (pulse): output <= 1 on the edge that fires, else 0; output is a one-cycle high pulse per period (constantly high when max=0).
REQ-020 mode=1 (toggle): output inverts on each fire; square wave with period 2*(max+1).
REQ-021 en=0: counter held at 0, output 0.
REQ-022 First fire after commit/restart: on the (max+1)-th count edge; the output is visible in the cycle that follows.
REQ-023 Channels SHALL be fully independent; the only sharing is the serial chain.

Reset
REQ-024 reset=1 SHALL asynchronously clear all shift fields, active registers, counters, channel outputs and the commit-pending flag; then tick_bus = {N_CH{0},1,0} and bs_out=0.
REQ-025 The first edge after reset release SHALL NOT commit.

Verification
REQ-026 N_CH=2, CNT_W=4: shift 12 bits for ch1 {1,0,0011} then 12 for ch0 {1,1,0001}, then drop config_en -> ch1 pulses every 4 cycles and ch0 toggles every 2 cycles, first ch1 pulse 4 cycles after commit.
REQ-027 Program a channel with max=0, mode=0, en=1 -> tick_bus[2] is 1 continuously from the second cycle after commit.
REQ-028 Shift the pattern 1,0,1,1 with config_en held high for chain length+4 cycles -> the same pattern appears on bs_out exactly N_CH*(CNT_W+2) cycles later.
REQ-029 Mid-period (count=2, max=5) raise restart for 1 cycle -> count=0, outputs 0, next pulse 6 cycles later; configuration unchanged.
REQ-030 Assert reset asynchronously mid-shift -> all outputs are immediately 0 (bit1=1); after release, all channels stay 0 without reconfiguration.
REQ-031 Raise config_en for 3 cycles mid-count -> outputs and counters frozen; on drop, the partially shifted configuration commits and counters restart from 0.

Source files
------------

// File: rtl/retospect_tickgen.sv
// Programmable tick generator: N_CH independent period counters configured
// through a daisy-chainable serial shift chain. Each channel produces either a
// one-cycle pulse or a toggling square wave per period.
module retospect_tickgen #(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            bs_in,
    output logic            bs_out,
    input  logic            restart,
    output logic [N_CH+1:0] tick_bus
);

    // Per-channel field is {en, mode, max}; channel 0 sits at the top of the
    // chain so bs_in enters its MSB and bs_out leaves the last channel's LSB.
    localparam int unsigned FW      = CNT_W + 2;
    localparam int unsigned CHAIN_W = N_CH * FW;

    logic [CHAIN_W-1:0]            chain_q, chain_d;
    logic [N_CH-1:0]               en_q, en_d;
    logic [N_CH-1:0]               mode_q, mode_d;
    logic [N_CH-1:0][CNT_W-1:0]    max_q, max_d;
    logic [N_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_CH-1:0]               out_q, out_d;
    logic                          pending_q, pending_d;
    logic [FW-1:0]                 field;

    // Next-state: restart > shift > commit > count.
    always_comb begin
        chain_d   = chain_q;
        en_d      = en_q;
        mode_d    = mode_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        pending_d = pending_q;
        field     = '0;

        if (restart) begin
            // Configuration untouched; a pending commit waits for restart to drop.
            cnt_d = '0;
            out_d = '0;
        end else if (config_en) begin
            chain_d   = {bs_in, chain_q[CHAIN_W-1:1]};
            pending_d = 1'b1;
        end else if (pending_q) begin
            pending_d = 1'b0;
            cnt_d     = '0;
            out_d     = '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                field     = chain_q[CHAIN_W-1-k*FW -: FW];
                en_d[k]   = field[FW-1];
                mode_d[k] = field[FW-2];
                max_d[k]  = field[CNT_W-1:0];
            end
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!en_q[k]) begin
                    cnt_d[k] = '0;
                    out_d[k] = 1'b0;
                end else if (cnt_q[k] == max_q[k]) begin
                    // Match is the only wrap path, so max = all-ones needs no overflow logic.
                    cnt_d[k] = '0;
                    out_d[k] = mode_q[k] ? ~out_q[k] : 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    out_d[k] = mode_q[k] ? out_q[k] : 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q   <= '0;
            en_q      <= '0;
            mode_q    <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            chain_q   <= chain_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            max_q     <= max_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            pending_q <= pending_d;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        bs_out   = chain_q[0];
        tick_bus = {out_q, 2'b10};
    end

endmodule

// File: tb/tb_retospect_tickgen.sv
// Directed bench for retospect_tickgen with N_CH=2, CNT_W=4 (6-bit fields,
// 12-bit chain). tick_bus layout: {ch1, ch0, 1, 0}.
module tb_retospect_tickgen;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            config_en = 1'b0;
    logic            bs_in = 1'b0;
    logic            restart = 1'b0;
    logic            bs_out;
    logic [N_CH+1:0] tick_bus;

    int n_tests = 0;
    int n_fail  = 0;

    retospect_tickgen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .config_en(config_en),
        .bs_in    (bs_in),
        .bs_out   (bs_out),
        .restart  (restart),
        .tick_bus (tick_bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift w[0] first; after 12 shifts the chain equals w ({ch0, ch1}).
    task automatic shift_bits(input logic [11:0] w, input int n);
        config_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            bs_in = w[i];
            tick();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    logic [15:0] pat;

    initial begin
        // Reset state
        #2;
        check_eq("reset_tick", tick_bus, 4'b0010);
        check_eq("reset_bsout", bs_out, 1'b0);
        #6 reset = 1'b0;

        // ch0 = {1,1,0001} toggle max1, ch1 = {1,0,0011} pulse max3
        shift_bits(12'b110001_100011, 12);
        check_eq("cfg_bsout", bs_out, 1'b1);
        tick();
        check_eq("commit_tick", tick_bus, 4'b0010);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq($sformatf("run_%0d", k), tick_bus,
                     {((k % 4) == 0) ? 1'b1 : 1'b0, ((k / 2) % 2 == 1) ? 1'b1 : 1'b0, 2'b10});
        end

        // Serial pass-through: pattern 1,0,1,1 then zeros
        pat = 16'b0000_0000_0000_1101;
        config_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            bs_in = pat[k-1];
            tick();
            if (k >= 12 && k <= 15)
                check_eq($sformatf("bs_pass_%0d", k - 12), bs_out, pat[k-12]);
        end
        check_eq("frozen_during_shift", tick_bus, 4'b1010);
        config_en = 1'b0;
        bs_in     = 1'b0;
        tick();
        check_eq("all_disabled_commit", tick_bus, 4'b0010);
        tick();
        tick();
        check_eq("all_disabled_run", tick_bus, 4'b0010);

        // max=0 pulse on ch0 -> constant high from second cycle after commit
        shift_bits(12'b100000_000000, 12);
        tick();
        check_eq("max0_commit", tick_bus, 4'b0010);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq($sformatf("max0_%0d", k), tick_bus, 4'b0110);
        end

        // ch0 pulse max5, ch1 toggle max5; restart on the would-be commit edge
        shift_bits(12'b100101_110101, 12);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("restart_clears", tick_bus, 4'b0010);
        tick();
        check_eq("delayed_commit", tick_bus, 4'b0010);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) check_eq("p5_e5", tick_bus, 4'b0010);
            if (k == 6) check_eq("p5_e6", tick_bus, 4'b1110);
            if (k == 8) check_eq("p5_e8", tick_bus, 4'b1010);
        end
        // count is 2 here; restart mid-period
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("mid_restart", tick_bus, 4'b0010);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) check_eq("post_restart_e5", tick_bus, 4'b0010);
            if (k == 6) check_eq("post_restart_e6", tick_bus, 4'b1110);
        end

        // Short config burst mid-count: freeze, then commit partial chain
        config_en = 1'b1;
        bs_in     = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("freeze_%0d", k), tick_bus, 4'b1110);
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
        // chain = 111100_101110: ch0 toggle max12, ch1 pulse max14
        tick();
        check_eq("partial_commit", tick_bus, 4'b0010);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 12) check_eq("part_e12", tick_bus, 4'b0010);
            if (k == 13) check_eq("part_e13", tick_bus, 4'b0110);
            if (k == 15) check_eq("part_e15", tick_bus, 4'b1110);
            if (k == 16) check_eq("part_e16", tick_bus, 4'b0110);
        end

        // Async reset mid-shift
        config_en = 1'b1;
        bs_in     = 1'b1;
        tick();
        tick();
        check_eq("pre_reset_bsout", bs_out, 1'b1);
        check_eq("pre_reset_tick", tick_bus, 4'b0110);
        #3 reset = 1'b1;
        #1;
        check_eq("async_reset_tick", tick_bus, 4'b0010);
        check_eq("async_reset_bsout", bs_out, 1'b0);
        #2;
        config_en = 1'b0;
        bs_in     = 1'b0;
        reset     = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq($sformatf("post_reset_%0d", k), tick_bus, 4'b0010);
        end
        check_eq("post_reset_bsout", bs_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
